// File: rtl/vram_bus_bridge_pkg.sv
// Shared definitions for the CPU-to-display bus bridge: bus status codes,
// opm field positions and bridge FSM state encoding.
package vram_bus_bridge_pkg;

  typedef enum logic [1:0] {
    UMEM_OK_READY = 2'd0,
    UMEM_OK_OK    = 2'd1,
    UMEM_OK_HOLD  = 2'd2,
    UMEM_OK_FAULT = 2'd3
  } umem_ok_e;

  localparam int         OPM_WR_BIT  = 4;
  localparam int         OPM_OE_BIT  = 3;
  localparam logic [2:0] OPM_SIZE_QW = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // A request is accepted only when exactly one of WR/OE is set.
  function automatic logic opm_is_access(input logic [4:0] opm);
    return opm[OPM_WR_BIT] ^ opm[OPM_OE_BIT];
  endfunction

endpackage

// File: rtl/vram_bus_bridge.sv
// Registered CPU MMIO to display-unit bus bridge with bounded WAIT.
// Optional macro VRAM_BRIDGE_TIMEOUT_EN enables the WAIT-state timeout counter.
module vram_bus_bridge
  import vram_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] reqAddr,
  input  logic [63:0] reqData,
  input  logic [4:0]  reqOpm,
  output logic [1:0]  reqOK,
  output logic [63:0] respData,
  output logic [31:0] vidAddr,
  output logic [63:0] vidDataOut,
  output logic [4:0]  vidOpm,
  input  logic [63:0] vidDataIn,
  input  logic [1:0]  vidOK
);

  state_e      state_r;
  logic [31:0] addr_r;
  logic [63:0] wdata_r;
  logic [4:0]  opm_r;
  logic [1:0]  ok_r;
  logic [63:0] resp_r;
  logic [31:0] vid_addr_r;
  logic [63:0] vid_data_r;
  logic [4:0]  vid_opm_r;
  logic        timeout_s;

`ifdef VRAM_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt_r;

  assign timeout_s = (cnt_r == 8'(TIMEOUT - 1));

  // WAIT-cycle counter, cleared on every ISSUE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= 8'd0;
    end else if (state_r == ST_ISSUE) begin
      cnt_r <= 8'd0;
    end else if ((state_r == ST_WAIT) && (vidOK != UMEM_OK_OK) && (vidOK != UMEM_OK_FAULT)) begin
      cnt_r <= cnt_r + 8'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  logic unused_timeout_s;

  assign timeout_s        = 1'b0;
  assign unused_timeout_s = ^8'(TIMEOUT);
`endif

  // Bridge FSM with all CPU- and display-facing outputs registered
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      addr_r     <= 32'd0;
      wdata_r    <= 64'd0;
      opm_r      <= 5'd0;
      ok_r       <= UMEM_OK_READY;
      resp_r     <= 64'd0;
      vid_addr_r <= 32'd0;
      vid_data_r <= 64'd0;
      vid_opm_r  <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          vid_opm_r <= 5'd0;
          if (reqOpm == 5'd0) begin
            ok_r    <= UMEM_OK_READY;
            state_r <= ST_IDLE;
          end else if (opm_is_access(reqOpm)) begin
            addr_r  <= reqAddr;
            wdata_r <= reqData;
            opm_r   <= reqOpm;
            ok_r    <= UMEM_OK_HOLD;
            state_r <= ST_ISSUE;
          end else begin
            // Malformed opm never reaches the display unit.
            ok_r    <= UMEM_OK_FAULT;
            state_r <= ST_DONE;
          end
        end
        ST_ISSUE: begin
          vid_addr_r <= addr_r;
          vid_data_r <= wdata_r;
          vid_opm_r  <= opm_r;
          ok_r       <= UMEM_OK_HOLD;
          state_r    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (vidOK == UMEM_OK_OK) begin
            if (!opm_r[OPM_WR_BIT]) begin
              resp_r <= vidDataIn;
            end else begin
              resp_r <= resp_r;
            end
            ok_r      <= UMEM_OK_OK;
            vid_opm_r <= 5'd0;
            state_r   <= ST_DONE;
          end else if ((vidOK == UMEM_OK_FAULT) || timeout_s) begin
            ok_r      <= UMEM_OK_FAULT;
            vid_opm_r <= 5'd0;
            state_r   <= ST_DONE;
          end else begin
            ok_r    <= UMEM_OK_HOLD;
            state_r <= ST_WAIT;
          end
        end
        ST_DONE: begin
          vid_opm_r <= 5'd0;
          // Both sides must be idle so neither sees a stale completion.
          if ((reqOpm == 5'd0) && (vidOK == UMEM_OK_READY)) begin
            ok_r    <= UMEM_OK_READY;
            state_r <= ST_IDLE;
          end else begin
            ok_r    <= ok_r;
            state_r <= ST_DONE;
          end
        end
        default: begin
          ok_r      <= UMEM_OK_READY;
          vid_opm_r <= 5'd0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  assign reqOK      = ok_r;
  assign respData   = resp_r;
  assign vidAddr    = vid_addr_r;
  assign vidDataOut = vid_data_r;
  assign vidOpm     = vid_opm_r;

endmodule
